mul_unit: RTL and testbench

- Iterative multiplier in the EX stage; the producer of the `Mul` stall request consumed by the hazard unit.
- While a multiply occupies EX it holds `Mul` high, which freezes F/D/E through StallF/StallD/StallE.
- It releases `Mul` for exactly one cycle with the product on `MulResultE`, so the instruction advances to MEM.
- Supports RV32M MUL, MULH, MULHSU and MULHU.

---
 rtl/mul_unit.sv | 120 ++++++++++++
 tb/tb_mul_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mul_unit.sv
// rtl/mul_unit.sv - iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU) driving the EX-stage Mul stall.
// Optional macro MUL_EARLY_OUT_EN ends the iteration once the remaining multiplier is zero.
module mul_unit #(
  parameter int XLEN = 32,
  parameter int STEP = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            MulReqE,
  input  logic [1:0]      MulOpE,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic            FlushE,
  output logic            Mul,
  output logic            MulDoneE,
  output logic [XLEN-1:0] MulResultE
);

  localparam int ITER = XLEN / STEP;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, stateNext;
  logic [XLEN:0]     mcand, mplier;
  logic              negRes;
  logic [1:0]        op;
  logic [2*XLEN-1:0] acc;
  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   result;
  logic              accept;

  logic [XLEN:0]     extA, extB, magA, magB;
  logic [2*XLEN-1:0] pp, accNext, prodFinal;
  logic [XLEN:0]     mplierNext;
  logic              lastIter;

  // Operands are extended to XLEN+1 bits so one unsigned datapath covers all four ops.
  always_comb begin
    extA = (MulOpE == 2'b01 || MulOpE == 2'b10) ? {SrcAE[XLEN-1], SrcAE} : {1'b0, SrcAE};
    extB = (MulOpE == 2'b01) ? {SrcBE[XLEN-1], SrcBE} : {1'b0, SrcBE};
    magA = extA[XLEN] ? -extA : extA;
    magB = extB[XLEN] ? -extB : extB;
  end

  always_comb begin
    pp = ({{(XLEN-1){1'b0}}, mcand} * {{(2*XLEN-STEP){1'b0}}, mplier[STEP-1:0]})
         << (int'(cnt) * STEP);
    accNext    = acc + pp;
    prodFinal  = negRes ? -accNext : accNext;
    mplierNext = mplier >> STEP;
`ifdef MUL_EARLY_OUT_EN
    lastIter = (cnt == CW'(ITER-1)) || (mplierNext == '0);
`else
    lastIter = (cnt == CW'(ITER-1));
`endif
  end

  always_comb begin
    stateNext = state;
    Mul       = 1'b0;
    MulDoneE  = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        accept = MulReqE & ~FlushE;
        Mul    = accept;
        if (accept) stateNext = BUSY;
      end
      BUSY: begin
        Mul = 1'b1;
        if (FlushE) stateNext = IDLE;
        else if (lastIter) stateNext = DONE;
      end
      DONE: begin
        MulDoneE  = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    // Stall and done are suppressed for the whole reset cycle, not just after the edge.
    if (rst) begin
      Mul      = 1'b0;
      MulDoneE = 1'b0;
      accept   = 1'b0;
    end
  end

  assign MulResultE = rst ? '0 : result;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      negRes <= 1'b0;
      op     <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      state <= stateNext;
      if (accept) begin
        mcand  <= magA;
        mplier <= magB;
        negRes <= extA[XLEN] ^ extB[XLEN];
        op     <= MulOpE;
        acc    <= '0;
        cnt    <= '0;
      end else if (state == BUSY && !FlushE) begin
        acc    <= accNext;
        mplier <= mplierNext;
        cnt    <= cnt + 1'b1;
        if (lastIter)
          result <= (op == 2'b00) ? prodFinal[XLEN-1:0] : prodFinal[2*XLEN-1:XLEN];
      end
    end
  end

endmodule

// File: tb/tb_mul_unit.sv
// tb/tb_mul_unit.sv - randomized self-checking bench for mul_unit against a 64-bit arithmetic model.
module tb_mul_unit;

  logic        clk = 1'b0;
  logic        rst, MulReqE, FlushE;
  logic [1:0]  MulOpE;
  logic [31:0] SrcAE, SrcBE;
  logic        Mul, MulDoneE;
  logic [31:0] MulResultE;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [31:0] lastRes = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mul_unit dut (
    .clk(clk), .rst(rst), .MulReqE(MulReqE), .MulOpE(MulOpE),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .FlushE(FlushE),
    .Mul(Mul), .MulDoneE(MulDoneE), .MulResultE(MulResultE)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic longint extend(input logic [31:0] v, input bit sgn);
    return sgn ? longint'($signed(v)) : longint'({32'd0, v});
  endfunction

  function automatic logic [31:0] refMul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = 64'(extend(a, op == 2'b01 || op == 2'b10) * extend(b, op == 2'b01));
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Cycles with Mul high: the accept cycle plus the number of iterations.
  function automatic int refLat(input logic [1:0] op, input logic [31:0] b);
    longint mb;
    int k;
    mb = extend(b, op == 2'b01);
    if (mb < 0) mb = -mb;
    k = 8;
`ifdef MUL_EARLY_OUT_EN
    k = 1;
    while (k < 8 && (mb >> (4 * k)) != 0) k++;
`endif
    return 1 + k;
  endfunction

  task automatic runMul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag, output int doneAt);
    logic [31:0] expRes;
    int busy;
    bit done;
    expRes = refMul(op, a, b);
    busy = 0;
    done = 0;
    doneAt = 0;
    MulReqE = 1'b1; MulOpE = op; SrcAE = a; SrcBE = b; FlushE = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (MulDoneE) begin
        done = 1;
        doneAt = cyc;
      end else begin
        if (Mul) busy++;
        @(negedge clk);
        SrcAE = $urandom;
        SrcBE = $urandom;
      end
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_lat"}, 32'(busy), 32'(refLat(op, b)));
    check({tag, "_res"}, MulResultE, expRes);
    check({tag, "_mulInDone"}, 32'(Mul), 32'd0);
    lastRes = expRes;
    @(negedge clk);
  endtask

  task automatic idleCycle(input string tag);
    MulReqE = 1'b0;
    #1;
    check({tag, "_idleMul"}, 32'(Mul), 32'd0);
    check({tag, "_idleDone"}, 32'(MulDoneE), 32'd0);
    check({tag, "_hold"}, MulResultE, lastRes);
    @(negedge clk);
  endtask

  initial begin
    int t1, t2, nMul, nDone;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    logic [31:0] corners [6];
    corners = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h10000};

    rst = 1'b1; MulReqE = 1'b1; FlushE = 1'b0; MulOpE = 2'b00; SrcAE = 32'd7; SrcBE = 32'd6;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_mul", 32'(Mul), 32'd0);
    check("rst_done", 32'(MulDoneE), 32'd0);
    check("rst_res", MulResultE, 32'd0);
    @(negedge clk);
    rst = 1'b0; MulReqE = 1'b0;
    @(negedge clk);

    runMul(2'b00, 32'd7, 32'd6, "mul7x6", t1);
    check("mul7x6_const", lastRes, 32'h0000002A);
    idleCycle("a");
    runMul(2'b01, 32'hFFFFFFFF, 32'h2, "mulh", t1);
    idleCycle("b");
    runMul(2'b11, 32'hFFFFFFFF, 32'h2, "mulhu", t1);
    idleCycle("c");
    runMul(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu", t1);
    idleCycle("d");
    runMul(2'b00, 32'h12345678, 32'h3, "early", t1);
    check("early_const", lastRes, 32'h369D0368);
    idleCycle("e");

    // Flush in the 4th busy cycle.
    MulReqE = 1'b1; MulOpE = 2'b00; SrcAE = 32'd100; SrcBE = 32'hFFFFFFFF;
    repeat (4) @(negedge clk);
    FlushE = 1'b1; MulReqE = 1'b0;
    #1;
    check("flush_busy", 32'(Mul), 32'd1);
    @(negedge clk);
    FlushE = 1'b0;
    nMul = 0; nDone = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (Mul) nMul++;
      if (MulDoneE) nDone++;
      @(negedge clk);
    end
    check("flush_mul", 32'(nMul), 32'd0);
    check("flush_done", 32'(nDone), 32'd0);
    runMul(2'b00, 32'd3, 32'd3, "after_flush", t1);
    idleCycle("f");

    // Reset in the 3rd busy cycle.
    MulReqE = 1'b1; MulOpE = 2'b00; SrcAE = 32'd55; SrcBE = 32'hFFFFFFFF;
    repeat (3) @(negedge clk);
    rst = 1'b1; MulReqE = 1'b0;
    @(negedge clk);
    #1;
    check("midrst_mul", 32'(Mul), 32'd0);
    check("midrst_done", 32'(MulDoneE), 32'd0);
    check("midrst_res", MulResultE, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    runMul(2'b00, 32'h10000, 32'h10000, "post_rst_mul", t1);
    runMul(2'b11, 32'h10000, 32'h10000, "post_rst_mulhu", t1);
    idleCycle("g");

    runMul(2'b00, 32'd5, 32'd5, "b2b1", t1);
    runMul(2'b01, 32'h80000000, 32'h80000000, "b2b2", t2);
    check("b2b_gap", 32'(t2 - t1), 32'(refLat(2'b01, 32'h80000000) + 1));
    check("b2b_const", lastRes, 32'h40000000);
    idleCycle("h");

    for (int n = 0; n < 40; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 32'($urandom >> $urandom_range(0, 31));
      runMul(rop, ra, rb, $sformatf("rnd%0d", n), t1);
      if ($urandom_range(0, 1) == 0) idleCycle($sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
